// File: rtl/ahb3lite_mlayer_master_port.sv
// AHB3-Lite multi-layer switch, master side: decodes the address, requests and holds
// slave access, replays interrupted bursts and answers unmapped or timed-out accesses with ERROR.
module ahb3lite_mlayer_master_port #(
  parameter int                HADDR_SIZE  = 32,
  parameter int                HDATA_SIZE  = 32,
  parameter int                MASTERS     = 3,
  parameter int                SLAVES      = 8,
  parameter logic [SLAVES-1:0] SLAVE_MASK  = {SLAVES{1'b1}},
  parameter int                TIMEOUT     = 0,
  localparam int               MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1,
  localparam int               SLAVE_BITS  = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic                              HCLK,
  input  logic                              HRESET,

  input  logic [MASTER_BITS-1:0]            mst_priority,
  input  logic                              mst_HSEL,
  input  logic [HADDR_SIZE-1:0]             mst_HADDR,
  input  logic [HDATA_SIZE-1:0]             mst_HWDATA,
  output logic [HDATA_SIZE-1:0]             mst_HRDATA,
  input  logic                              mst_HWRITE,
  input  logic [2:0]                        mst_HSIZE,
  input  logic [2:0]                        mst_HBURST,
  input  logic [3:0]                        mst_HPROT,
  input  logic [1:0]                        mst_HTRANS,
  input  logic                              mst_HMASTLOCK,
  output logic                              mst_HREADYOUT,
  input  logic                              mst_HREADY,
  output logic                              mst_HRESP,

  input  logic [SLAVES-1:0][HADDR_SIZE-1:0] slvHADDRmask,
  input  logic [SLAVES-1:0][HADDR_SIZE-1:0] slvHADDRbase,
  output logic [SLAVES-1:0]                 slvHSEL,
  output logic [HADDR_SIZE-1:0]             slvHADDR,
  output logic [HDATA_SIZE-1:0]             slvHWDATA,
  input  logic [SLAVES-1:0][HDATA_SIZE-1:0] slvHRDATA,
  output logic                              slvHWRITE,
  output logic [2:0]                        slvHSIZE,
  output logic [2:0]                        slvHBURST,
  output logic [3:0]                        slvHPROT,
  output logic [1:0]                        slvHTRANS,
  output logic                              slvHMASTLOCK,
  output logic                              slvHREADYOUT,
  input  logic [SLAVES-1:0]                 slvHREADY,
  input  logic [SLAVES-1:0]                 slvHRESP,

  output logic                              can_switch,
  output logic [MASTER_BITS-1:0]            slvpriority,
  input  logic [SLAVES-1:0]                 master_granted,

  output logic                              err_unmapped,
  output logic                              err_timeout
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam int         TCNT_W        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_PENDING, ST_GRANTED, ST_ERR1, ST_ERR2} state_t;

  state_t                  state;
  logic [SLAVES-1:0]       hit, current_HSEL;
  logic [SLAVE_BITS-1:0]   current_sel, slave_sel;
  logic                    req, mapped, unmapped, cur_granted, cur_go, pend_go, timeout_hit;
  logic [3:0]              burst_cnt;
  logic [TCNT_W-1:0]       tcnt;

  logic [HADDR_SIZE-1:0]   reg_HADDR;
  logic                    reg_HWRITE, reg_HMASTLOCK;
  logic [2:0]              reg_HSIZE, reg_HBURST;
  logic [3:0]              reg_HPROT;
  logic [1:0]              reg_HTRANS;
  logic [SLAVES-1:0]       reg_HSEL;
  logic [MASTER_BITS-1:0]  reg_priority;

  // Address decode; overlapping regions resolve to the lowest slave index
  always_comb begin
    hit = '0;
    for (int s = 0; s < SLAVES; s++)
      hit[s] = SLAVE_MASK[s] & ((mst_HADDR & slvHADDRmask[s]) == (slvHADDRbase[s] & slvHADDRmask[s]));
    current_HSEL = hit & (~hit + SLAVES'(1));
    current_sel  = '0;
    for (int s = 0; s < SLAVES; s++)
      if (current_HSEL[s]) current_sel = SLAVE_BITS'(s);
  end

  assign req         = mst_HSEL & mst_HTRANS[1];
  assign mapped      = req & (|current_HSEL);
  assign unmapped    = req & ~(|current_HSEL);
  assign cur_granted = |(current_HSEL & master_granted);
  assign cur_go      = |(current_HSEL & master_granted & slvHREADY);
  assign pend_go     = master_granted[slave_sel] & slvHREADY[slave_sel];
  assign timeout_hit = (TIMEOUT > 0) && (state == ST_PENDING) && !pend_go &&
                       (tcnt == TCNT_W'(TIMEOUT - 1));

  // Address phase capture, replayed while waiting for a grant
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      reg_HTRANS <= HTRANS_IDLE;
      reg_HSEL   <= '0;
    end else if (mst_HREADY) begin
      reg_HTRANS <= mst_HSEL ? mst_HTRANS : HTRANS_IDLE;
      reg_HSEL   <= mst_HSEL ? current_HSEL : '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (mst_HREADY) begin
      reg_HADDR     <= mst_HADDR;
      reg_HWRITE    <= mst_HWRITE;
      reg_HSIZE     <= mst_HSIZE;
      reg_HBURST    <= mst_HBURST;
      reg_HPROT     <= mst_HPROT;
      reg_HMASTLOCK <= mst_HMASTLOCK;
      reg_priority  <= mst_priority;
    end
  end

  // Remaining SEQ beats of a fixed-length burst after the current one
  always_ff @(posedge HCLK) begin
    if (HRESET)
      burst_cnt <= '0;
    else if (mst_HREADY && mst_HSEL) begin
      if (mst_HTRANS == HTRANS_NONSEQ) begin
        case (mst_HBURST)
          3'b010, 3'b011: burst_cnt <= 4'd2;
          3'b100, 3'b101: burst_cnt <= 4'd6;
          3'b110, 3'b111: burst_cnt <= 4'd14;
          default:        burst_cnt <= 4'd0;
        endcase
      end else if (mst_HTRANS == HTRANS_SEQ && burst_cnt != 4'd0)
        burst_cnt <= burst_cnt - 4'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET || state != ST_PENDING) tcnt <= '0;
    else                               tcnt <= tcnt + TCNT_W'(1);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= ST_IDLE;
      slave_sel    <= '0;
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (mst_HREADY && unmapped) begin
            state        <= ST_ERR1;
            err_unmapped <= 1'b1;
          end else if (mst_HREADY && mapped) begin
            slave_sel <= current_sel;
            state     <= cur_granted ? ST_GRANTED : ST_PENDING;
          end else
            state <= ST_IDLE;
        end
        ST_PENDING: begin
          if (pend_go)
            state <= ST_GRANTED;
          else if (timeout_hit) begin
            state       <= ST_ERR1;
            err_timeout <= 1'b1;
          end
        end
        ST_GRANTED: begin
          if (mst_HREADY) begin
            if (unmapped) begin
              state        <= ST_ERR1;
              err_unmapped <= 1'b1;
            end else if (mapped) begin
              slave_sel <= current_sel;
              state     <= cur_go ? ST_GRANTED : ST_PENDING;
            end else
              state <= ST_IDLE;
          end
        end
        ST_ERR1: state <= ST_ERR2;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mst_HREADYOUT = 1'b1;
    mst_HRESP     = 1'b0;
    mst_HRDATA    = '0;
    case (state)
      ST_PENDING: mst_HREADYOUT = 1'b0;
      ST_GRANTED: begin
        mst_HREADYOUT = slvHREADY[slave_sel];
        mst_HRESP     = slvHRESP[slave_sel];
        mst_HRDATA    = slvHRDATA[slave_sel];
      end
      ST_ERR1: begin
        mst_HREADYOUT = 1'b0;
        mst_HRESP     = 1'b1;
      end
      ST_ERR2: mst_HRESP = 1'b1;
      default: ;
    endcase
  end

  // A replayed burst remainder is restarted as NONSEQ of undefined length
  always_comb begin
    slvHWDATA = mst_HWDATA;
    if (state == ST_PENDING) begin
      slvHSEL      = timeout_hit ? '0 : reg_HSEL;
      slvHADDR     = reg_HADDR;
      slvHWRITE    = reg_HWRITE;
      slvHSIZE     = reg_HSIZE;
      slvHBURST    = (reg_HBURST[2:1] != 2'b00) ? HBURST_INCR : reg_HBURST;
      slvHPROT     = reg_HPROT;
      slvHTRANS    = (reg_HTRANS == HTRANS_SEQ) ? HTRANS_NONSEQ : reg_HTRANS;
      slvHMASTLOCK = reg_HMASTLOCK;
      slvpriority  = reg_priority;
      slvHREADYOUT = slvHREADY[slave_sel];
    end else begin
      slvHSEL      = (state == ST_ERR1 || state == ST_ERR2) ? '0 : ({SLAVES{mst_HSEL}} & current_HSEL);
      slvHADDR     = mst_HADDR;
      slvHWRITE    = mst_HWRITE;
      slvHSIZE     = mst_HSIZE;
      slvHBURST    = mst_HBURST;
      slvHPROT     = mst_HPROT;
      slvHTRANS    = mst_HTRANS;
      slvHMASTLOCK = mst_HMASTLOCK;
      slvpriority  = mst_priority;
      slvHREADYOUT = mst_HREADY & (|(current_HSEL & slvHREADY));
    end
  end

  // Undefined-length INCR never releases the slave mid-burst
  always_comb begin
    case (state)
      ST_PENDING: can_switch = ~master_granted[slave_sel];
      ST_GRANTED: can_switch = ~mst_HSEL |
                               (~mst_HMASTLOCK & mst_HREADY &
                                ((mst_HTRANS == HTRANS_IDLE) ||
                                 (mst_HTRANS == HTRANS_NONSEQ && mst_HBURST == HBURST_SINGLE) ||
                                 (mst_HTRANS == HTRANS_SEQ && mst_HBURST[2:1] != 2'b00 &&
                                  burst_cnt == 4'd0)));
      default:    can_switch = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ahb3lite_mlayer_master_port.sv
// Directed bench for the multi-layer master port: decode, error pair, burst replay, timeout, reset.
module tb_ahb3lite_mlayer_master_port;
  localparam int SLAVES = 8;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR8 = 3'b101;

  logic                     HCLK = 1'b0;
  logic                     HRESET;
  logic [1:0]               mst_priority;
  logic                     mst_HSEL, mst_HWRITE, mst_HMASTLOCK, mst_HREADY;
  logic [31:0]              mst_HADDR, mst_HWDATA, mst_HRDATA;
  logic [2:0]               mst_HSIZE, mst_HBURST;
  logic [3:0]               mst_HPROT;
  logic [1:0]               mst_HTRANS;
  logic                     mst_HREADYOUT, mst_HRESP;
  logic [SLAVES-1:0][31:0]  slvHADDRmask, slvHADDRbase, slvHRDATA;
  logic [SLAVES-1:0]        slvHSEL, slvHREADY, slvHRESP, master_granted;
  logic [31:0]              slvHADDR, slvHWDATA;
  logic                     slvHWRITE, slvHMASTLOCK, slvHREADYOUT, can_switch;
  logic [2:0]               slvHSIZE, slvHBURST;
  logic [3:0]               slvHPROT;
  logic [1:0]               slvHTRANS, slvpriority;
  logic                     err_unmapped, err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;
  assign mst_HREADY = mst_HREADYOUT;

  ahb3lite_mlayer_master_port #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(3), .SLAVES(SLAVES), .TIMEOUT(4)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .mst_priority(mst_priority), .mst_HSEL(mst_HSEL), .mst_HADDR(mst_HADDR),
    .mst_HWDATA(mst_HWDATA), .mst_HRDATA(mst_HRDATA), .mst_HWRITE(mst_HWRITE),
    .mst_HSIZE(mst_HSIZE), .mst_HBURST(mst_HBURST), .mst_HPROT(mst_HPROT),
    .mst_HTRANS(mst_HTRANS), .mst_HMASTLOCK(mst_HMASTLOCK),
    .mst_HREADYOUT(mst_HREADYOUT), .mst_HREADY(mst_HREADY), .mst_HRESP(mst_HRESP),
    .slvHADDRmask(slvHADDRmask), .slvHADDRbase(slvHADDRbase), .slvHSEL(slvHSEL),
    .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA), .slvHRDATA(slvHRDATA),
    .slvHWRITE(slvHWRITE), .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST),
    .slvHPROT(slvHPROT), .slvHTRANS(slvHTRANS), .slvHMASTLOCK(slvHMASTLOCK),
    .slvHREADYOUT(slvHREADYOUT), .slvHREADY(slvHREADY), .slvHRESP(slvHRESP),
    .can_switch(can_switch), .slvpriority(slvpriority), .master_granted(master_granted),
    .err_unmapped(err_unmapped), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [31:0] a, input logic [1:0] tr, input logic [2:0] bu);
    mst_HSEL   = sel;
    mst_HADDR  = a;
    mst_HTRANS = tr;
    mst_HBURST = bu;
  endtask

  initial begin
    HRESET = 1'b1;
    mst_priority = 2'd1; mst_HWDATA = '0; mst_HWRITE = 1'b0; mst_HSIZE = 3'b010;
    mst_HPROT = 4'b0011; mst_HMASTLOCK = 1'b0;
    drive(1'b0, 32'h0, IDLE, SINGLE);
    slvHADDRbase = '0; slvHADDRmask = '0;
    slvHADDRbase[0] = 32'h9000_0000; slvHADDRmask[0] = 32'hF000_0000;
    slvHADDRbase[1] = 32'h0000_1000; slvHADDRmask[1] = 32'h0000_F000;
    slvHADDRbase[2] = 32'h0000_2000; slvHADDRmask[2] = 32'h0000_F000;
    slvHADDRbase[3] = 32'h0000_1000; slvHADDRmask[3] = 32'h0000_FF00;
    slvHADDRbase[4] = 32'h0000_4000; slvHADDRmask[4] = 32'h0000_F000;
    slvHADDRbase[5] = 32'hA000_0000; slvHADDRmask[5] = 32'hF000_0000;
    slvHADDRbase[6] = 32'hB000_0000; slvHADDRmask[6] = 32'hF000_0000;
    slvHADDRbase[7] = 32'hC000_0000; slvHADDRmask[7] = 32'hF000_0000;
    for (int s = 0; s < SLAVES; s++) slvHRDATA[s] = 32'hD000_0000 + 32'(s);
    slvHREADY = '1; slvHRESP = '0;
    master_granted = 8'b0000_0110;

    tick(); tick(); #1;
    chk("rst_hreadyout", 32'(mst_HREADYOUT), 32'h1);
    chk("rst_hresp", 32'(mst_HRESP), 32'h0);
    chk("rst_slvhsel", 32'(slvHSEL), 32'h0);
    chk("rst_can_switch", 32'(can_switch), 32'h1);
    chk("rst_err_unmapped", 32'(err_unmapped), 32'h0);
    chk("rst_err_timeout", 32'(err_timeout), 32'h0);
    chk("rst_hrdata", mst_HRDATA, 32'h0);
    HRESET = 1'b0;

    // SINGLE read to slave 2
    tick(); drive(1'b1, 32'h2004, NONSEQ, SINGLE); #1;
    chk("single_slvhsel", 32'(slvHSEL), 32'h04);
    chk("single_slvhreadyout", 32'(slvHREADYOUT), 32'h1);
    tick(); drive(1'b0, 32'h0, IDLE, SINGLE); #1;
    chk("single_hrdata", mst_HRDATA, 32'hD000_0002);
    chk("single_hresp", 32'(mst_HRESP), 32'h0);
    chk("single_hreadyout", 32'(mst_HREADYOUT), 32'h1);
    tick(); #1;
    chk("idle_hrdata_zero", mst_HRDATA, 32'h0);

    // Overlapping regions: slave 1 wins over slave 3
    drive(1'b1, 32'h1000, NONSEQ, SINGLE); #1;
    chk("overlap_slvhsel", 32'(slvHSEL), 32'h02);
    tick(); drive(1'b0, 32'h0, IDLE, SINGLE); #1;
    chk("overlap_hrdata", mst_HRDATA, 32'hD000_0001);
    tick();

    // Unmapped access gets the two-cycle ERROR
    drive(1'b1, 32'hF000, NONSEQ, SINGLE); #1;
    chk("unmap_slvhsel", 32'(slvHSEL), 32'h0);
    tick(); drive(1'b0, 32'h0, IDLE, SINGLE); #1;
    chk("unmap_err1_hreadyout", 32'(mst_HREADYOUT), 32'h0);
    chk("unmap_err1_hresp", 32'(mst_HRESP), 32'h1);
    chk("unmap_err1_pulse", 32'(err_unmapped), 32'h1);
    chk("unmap_err1_slvhsel", 32'(slvHSEL), 32'h0);
    tick(); #1;
    chk("unmap_err2_hreadyout", 32'(mst_HREADYOUT), 32'h1);
    chk("unmap_err2_hresp", 32'(mst_HRESP), 32'h1);
    chk("unmap_err2_pulse", 32'(err_unmapped), 32'h0);
    tick(); #1;
    chk("unmap_after_hresp", 32'(mst_HRESP), 32'h0);

    // INCR8 on slave 4, grant lost while beat 4 address is presented
    master_granted = 8'b0001_0110;
    drive(1'b1, 32'h4000, NONSEQ, INCR8); #1;
    chk("incr8_b1_can_switch", 32'(can_switch), 32'h1);
    tick(); drive(1'b1, 32'h4004, SEQ, INCR8); #1;
    chk("incr8_b2_can_switch", 32'(can_switch), 32'h0);
    tick(); drive(1'b1, 32'h4008, SEQ, INCR8);
    tick(); drive(1'b1, 32'h400C, SEQ, INCR8); master_granted[4] = 1'b0; #1;
    chk("incr8_b4_can_switch", 32'(can_switch), 32'h0);
    tick(); drive(1'b1, 32'h4010, SEQ, INCR8); #1;
    chk("replay_hreadyout", 32'(mst_HREADYOUT), 32'h0);
    chk("replay_haddr", slvHADDR, 32'h400C);
    chk("replay_htrans", 32'(slvHTRANS), 32'(NONSEQ));
    chk("replay_hburst", 32'(slvHBURST), 32'(INCR));
    chk("replay_slvhsel", 32'(slvHSEL), 32'h10);
    chk("replay_can_switch_ungranted", 32'(can_switch), 32'h1);
    tick(); #1;
    chk("replay_wait2", 32'(mst_HREADYOUT), 32'h0);
    master_granted[4] = 1'b1; #1;
    chk("replay_can_switch_granted", 32'(can_switch), 32'h0);
    tick(); #1;
    chk("resume_hreadyout", 32'(mst_HREADYOUT), 32'h1);
    chk("resume_hrdata", mst_HRDATA, 32'hD000_0004);
    chk("resume_b5_haddr", slvHADDR, 32'h4010);
    chk("resume_b5_can_switch", 32'(can_switch), 32'h0);
    tick(); drive(1'b1, 32'h4014, SEQ, INCR8);
    tick(); drive(1'b1, 32'h4018, SEQ, INCR8); #1;
    chk("incr8_b7_can_switch", 32'(can_switch), 32'h0);
    tick(); drive(1'b1, 32'h401C, SEQ, INCR8); #1;
    chk("incr8_b8_can_switch", 32'(can_switch), 32'h1);
    tick(); drive(1'b0, 32'h0, IDLE, SINGLE);
    tick();

    // Slave 5 never granted: four PENDING cycles then ERROR
    drive(1'b1, 32'hA000_0000, NONSEQ, SINGLE); #1;
    chk("tmo_slvhsel_req", 32'(slvHSEL), 32'h20);
    tick(); drive(1'b0, 32'h0, IDLE, SINGLE);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tmo_pending_hreadyout", 32'(mst_HREADYOUT), 32'h0);
      chk("tmo_pending_slvhsel", 32'(slvHSEL), (i == 3) ? 32'h0 : 32'h20);
      chk("tmo_pending_pulse", 32'(err_timeout), 32'h0);
      tick();
    end
    #1;
    chk("tmo_err1_hreadyout", 32'(mst_HREADYOUT), 32'h0);
    chk("tmo_err1_hresp", 32'(mst_HRESP), 32'h1);
    chk("tmo_err1_pulse", 32'(err_timeout), 32'h1);
    tick(); #1;
    chk("tmo_err2_hreadyout", 32'(mst_HREADYOUT), 32'h1);
    chk("tmo_err2_hresp", 32'(mst_HRESP), 32'h1);
    chk("tmo_err2_pulse", 32'(err_timeout), 32'h0);
    tick();

    // Grant arriving on the last allowed PENDING cycle beats the timeout
    drive(1'b1, 32'hA000_0000, NONSEQ, SINGLE);
    tick(); drive(1'b0, 32'h0, IDLE, SINGLE);
    tick(); tick(); tick();
    master_granted[5] = 1'b1; #1;
    chk("race_slvhsel", 32'(slvHSEL), 32'h20);
    tick(); #1;
    chk("race_hrdata", mst_HRDATA, 32'hD000_0005);
    chk("race_hresp", 32'(mst_HRESP), 32'h0);
    chk("race_no_timeout", 32'(err_timeout), 32'h0);
    master_granted[5] = 1'b0;
    tick();

    // Reset while PENDING
    drive(1'b1, 32'hA000_0000, NONSEQ, SINGLE);
    tick(); drive(1'b0, 32'h0, IDLE, SINGLE); #1;
    chk("rstp_pending", 32'(mst_HREADYOUT), 32'h0);
    HRESET = 1'b1;
    tick(); #1;
    chk("rstp_slvhsel", 32'(slvHSEL), 32'h0);
    chk("rstp_hreadyout", 32'(mst_HREADYOUT), 32'h1);
    chk("rstp_can_switch", 32'(can_switch), 32'h1);
    chk("rstp_hresp", 32'(mst_HRESP), 32'h0);
    HRESET = 1'b0;
    tick(); tick(); tick(); tick(); #1;
    chk("rstp_no_resume_hreadyout", 32'(mst_HREADYOUT), 32'h1);
    chk("rstp_no_resume_hresp", 32'(mst_HRESP), 32'h0);
    chk("rstp_no_timeout", 32'(err_timeout), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
